// File: rtl/sub16_serial_pkg.sv
// Shared definitions for the bit-serial subtractor and its neighbours.
//   HACK_WORD   : default datapath width of the Hack machine word.
//   state_t     : sequencer states (IDLE / RUN / DONE), 2-bit encoding.
//   cnt_width() : width of a bit counter that can reach w without wrapping.
package hack_pkg;

    localparam int HACK_WORD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // log2(w)+1 bits, so the counter can hold w itself after the last bit
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int HACK_CNT_W = cnt_width(HACK_WORD);

endpackage

// File: rtl/sub16_serial_if.sv
// Handshake/data bundle of the serial subtractor.
//   start        : request, honoured only while the unit is idle
//   a, b         : minuend / subtrahend, captured on an accepted start
//   busy         : high while bits are being processed
//   done         : one-cycle completion pulse
//   out          : a - b mod 2^WIDTH, held until the next completion
//   zr, ng       : out == 0, out MSB
//   borrow       : unsigned borrow-out (a < b)
// master = requester side, slave = subtractor side.
interface sub16_serial_if
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_WORD
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, out, zr, ng, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, out, zr, ng, borrow
    );
endinterface

// File: rtl/sub16_serial_full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
//   a, b, bin : operand bits and incoming borrow
//   d         : difference bit
//   bout      : outgoing borrow
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Pure combinational cell; borrow arises when b exceeds a, or when
    // the bits are equal and a borrow is already pending.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/sub16_serial.sv
// Bit-serial subtractor: out = a - b over WIDTH cycles, LSB first, with a
// single full_sub cell and a borrow flip-flop.
//   clk   : system clock, rising-edge
//   reset : synchronous active-high reset, aborts any operation in flight
//   bus   : sub16_serial_if slave (start/a/b in; busy/done/out/flags out)
// Result and flags are written only at completion, so they stay stable
// through a following RUN; the partial result lives in its own register.
module sub16_serial
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_WORD
) (
    input  logic          clk,
    input  logic          reset,
    sub16_serial_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             bin_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] out_r;
    logic             zr_r;
    logic             ng_r;
    logic             borrow_r;
    logic             busy_r;
    logic             done_r;

    logic             d_s;
    logic             bout_s;
    logic [WIDTH-1:0] res_next_s;

    full_sub u_full_sub (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (bin_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Partial result after this bit: new difference bit enters at the MSB,
    // so after WIDTH shifts bit 0 of the operands lands in bit 0.
    always_comb begin
        res_next_s = {d_s, res_sh_r[WIDTH-1:1]};
    end

    // Sequencer, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            bin_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            out_r    <= {WIDTH{1'b0}};
            zr_r     <= 1'b0;
            ng_r     <= 1'b0;
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        bin_r   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    res_sh_r <= res_next_s;
                    bin_r    <= bout_s;
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Last bit: publish the full word and flags in this edge.
                    if (cnt_r == LAST_BIT) begin
                        out_r    <= res_next_s;
                        zr_r     <= (res_next_s == {WIDTH{1'b0}});
                        ng_r     <= res_next_s[WIDTH-1];
                        borrow_r <= bout_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        state_r  <= RUN;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.out    = out_r;
    assign bus.zr     = zr_r;
    assign bus.ng     = ng_r;
    assign bus.borrow = borrow_r;

endmodule
